mac_tile: RTL and testbench

- One processing element of the 2D systolic array, wrapping the mac arithmetic unit with pipeline registers.
- Activations and instructions enter from the west and are forwarded east one cycle later. Partial sums enter from the north and leave south.
- Each tile captures exactly one weight per kernel-load phase, then forwards later load tokens east so a weight row fills left to right.

---
 rtl/mac_pkg.sv | 11 +
 rtl/mac_tile_if.sv | 26 ++
 rtl/mac.sv | 25 ++
 rtl/mac_tile.sv | 78 +++++++
 tb/tb_mac_tile.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared constants and types for the systolic-array MAC tile.
package mac_pkg;

    localparam int BW        = 4;
    localparam int PSUM_BW   = 16;
    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;

    typedef logic [1:0] inst_t;

endpackage

// File: rtl/mac_tile_if.sv
// West/north inputs and east/south outputs of one systolic tile.
interface mac_tile_if
    import mac_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW
) ();

    logic [bw-1:0]      in_w;
    logic [bw-1:0]      out_e;
    inst_t              inst_w;
    inst_t              inst_e;
    logic [psum_bw-1:0] in_n;
    logic [psum_bw-1:0] out_s;

    modport master (
        output in_w, inst_w, in_n,
        input  out_e, inst_e, out_s
    );

    modport slave (
        input  in_w, inst_w, in_n,
        output out_e, inst_e, out_s
    );

endinterface

// File: rtl/mac.sv
// Multiply-accumulate: out = c + zext(a) * signed(b), wrapping modulo 2^psum_bw.
module mac
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic [bw-1:0]      a,
    input  logic [bw-1:0]      b,
    input  logic [psum_bw-1:0] c,
    output logic [psum_bw-1:0] out
);

    logic [2*bw:0]      a_ext_s;
    logic [2*bw:0]      b_ext_s;
    logic [2*bw:0]      product_s;
    logic [psum_bw-1:0] product_ext_s;

    // Exact product fits in 2*bw+1 signed bits, so a truncated multiply is exact.
    assign a_ext_s       = {{(bw + 1){1'b0}}, a};
    assign b_ext_s       = {{(bw + 1){b[bw-1]}}, b};
    assign product_s     = a_ext_s * b_ext_s;
    assign product_ext_s = {{(psum_bw - 2*bw - 1){product_s[2*bw]}}, product_s};
    assign out           = c + product_ext_s;

endmodule

// File: rtl/mac_tile.sv
// One systolic processing element: pipelines west/north inputs around a mac unit.
// Optional registered south output when MAC_TILE_OUT_REG_EN is defined.
module mac_tile
    import mac_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW
) (
    input  logic       clk,
    input  logic       reset_n,
    mac_tile_if.slave  tile
);

    logic [bw-1:0]      a_q;
    logic [bw-1:0]      b_q;
    logic [psum_bw-1:0] c_q;
    inst_t              inst_q;
    logic               load_ready_q;
    logic [psum_bw-1:0] mac_s;
    logic               weight_capture_s;

    assign weight_capture_s = tile.inst_w[INST_LOAD] & load_ready_q;

    // Operand pipeline; the first load token is consumed here and not forwarded east.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q          <= {bw{1'b0}};
            b_q          <= {bw{1'b0}};
            c_q          <= {psum_bw{1'b0}};
            inst_q       <= 2'b00;
            load_ready_q <= 1'b1;
        end else begin
            c_q               <= tile.in_n;
            inst_q[INST_EXEC] <= tile.inst_w[INST_EXEC];
            if (tile.inst_w != 2'b00) begin
                a_q <= tile.in_w;
            end
            if (weight_capture_s) begin
                b_q          <= tile.in_w;
                load_ready_q <= 1'b0;
            end
            if (!load_ready_q) begin
                inst_q[INST_LOAD] <= tile.inst_w[INST_LOAD];
            end
        end
    end

    mac #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) u_mac (
        .a   (a_q),
        .b   (b_q),
        .c   (c_q),
        .out (mac_s)
    );

    assign tile.out_e  = a_q;
    assign tile.inst_e = inst_q;

`ifdef MAC_TILE_OUT_REG_EN
    logic [psum_bw-1:0] out_s_q;

    // South output only updates on the edge after an execute token arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_s_q <= {psum_bw{1'b0}};
        end else if (inst_q[INST_EXEC]) begin
            out_s_q <= mac_s;
        end
    end

    assign tile.out_s = out_s_q;
`else
    assign tile.out_s = mac_s;
`endif

endmodule

// File: tb/tb_mac_tile.sv
// Self-checking bench for mac_tile: directed table, corner sequences, randomized run vs. model.
module tb_mac_tile;
    import mac_pkg::*;

    localparam int BWT = 4;
    localparam int PBW = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mac_tile_if #(.bw(BWT), .psum_bw(PBW)) bus ();

    mac_tile #(.bw(BWT), .psum_bw(PBW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tile    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: tile state in plain integer terms
    bit          m_loaded;
    int          m_weight;
    int          m_act;
    int          m_psum;
    logic [1:0]  m_inst_e;
    logic [15:0] m_outreg;

    typedef struct {
        logic [1:0]  inst;
        logic [3:0]  in_w;
        logic [15:0] in_n;
        logic [3:0]  out_e;
        logic [1:0]  inst_e;
        logic [15:0] out_s;
        logic [15:0] out_s_reg;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [15:0] m_mac(int act, int w, int ps);
        int r;
        r = ps + act * w;
        return r[15:0];
    endfunction

    function automatic logic [15:0] m_out_s();
`ifdef MAC_TILE_OUT_REG_EN
        return m_outreg;
`else
        return m_mac(m_act, m_weight, m_psum);
`endif
    endfunction

    task automatic m_reset();
        m_loaded = 1'b0;
        m_weight = 0;
        m_act    = 0;
        m_psum   = 0;
        m_inst_e = 2'b00;
        m_outreg = 16'h0000;
    endtask

    task automatic m_edge(logic [1:0] inst, logic [3:0] inw, logic [15:0] inn);
        if (m_inst_e[1]) m_outreg = m_mac(m_act, m_weight, m_psum);
        m_inst_e = {inst[1], (m_loaded ? inst[0] : 1'b0)};
        if (inst[0] && !m_loaded) begin
            m_weight = int'($signed(inw));
            m_loaded = 1'b1;
        end
        if (inst != 2'b00) m_act = int'(inw);
        m_psum = int'(inn);
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(string name);
        check({name, "_out_e"},  {12'h000, bus.out_e},  16'h0000);
        check({name, "_inst_e"}, {14'h0000, bus.inst_e}, 16'h0000);
        check({name, "_out_s"},  bus.out_s,              16'h0000);
    endtask

    task automatic check_model(string name);
        logic [3:0] ea;
        ea = m_act[3:0];
        check({name, "_out_e"},  {12'h000, bus.out_e},  {12'h000, ea});
        check({name, "_inst_e"}, {14'h0000, bus.inst_e}, {14'h0000, m_inst_e});
        check({name, "_out_s"},  bus.out_s,              m_out_s());
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step(logic [1:0] inst, logic [3:0] inw, logic [15:0] inn);
        bus.inst_w = inst;
        bus.in_w   = inw;
        bus.in_n   = inn;
        @(posedge clk);
        m_edge(inst, inw, inn);
        @(negedge clk);
    endtask

    task automatic async_reset_pulse();
        #3;
        reset_n = 1'b0;
        m_reset();
        #1;
        check_zero("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{2'b01, 4'hD, 16'h0000, 4'hD, 2'b00, 16'hFFD9, 16'h0000};
        tbl[1] = '{2'b01, 4'h5, 16'h0000, 4'h5, 2'b01, 16'hFFF1, 16'h0000};
        tbl[2] = '{2'b10, 4'h7, 16'd100,  4'h7, 2'b10, 16'h004F, 16'h0000};
        tbl[3] = '{2'b00, 4'h3, 16'h0000, 4'h7, 2'b00, 16'hFFEB, 16'h004F};
        tbl[4] = '{2'b00, 4'h0, 16'h0000, 4'h7, 2'b00, 16'hFFEB, 16'h004F};
        tbl[5] = '{2'b10, 4'hF, 16'h0000, 4'hF, 2'b10, 16'hFFD3, 16'h004F};
        tbl[6] = '{2'b01, 4'h2, 16'h0005, 4'h2, 2'b01, 16'hFFFF, 16'hFFD3};
        tbl[7] = '{2'b11, 4'h4, 16'h7FFF, 4'h4, 2'b11, 16'h7FF3, 16'hFFD3};
        tbl[8] = '{2'b10, 4'h0, 16'h8000, 4'h0, 2'b10, 16'h8000, 16'h7FF3};

        // Reset held with random inputs
        reset_n    = 1'b0;
        m_reset();
        bus.inst_w = 2'($urandom_range(0, 3));
        bus.in_w   = 4'($urandom);
        bus.in_n   = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("reset_hold");
            bus.inst_w = 2'($urandom_range(0, 3));
            bus.in_w   = 4'($urandom);
            bus.in_n   = 16'($urandom);
        end
        reset_n = 1'b1;

        // Directed table: load -3, execute, hold, unsigned activation, late load tokens, wrap
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].inst, tbl[i].in_w, tbl[i].in_n);
            check($sformatf("tbl%0d_out_e", i),  {12'h000, bus.out_e},  {12'h000, tbl[i].out_e});
            check($sformatf("tbl%0d_inst_e", i), {14'h0000, bus.inst_e}, {14'h0000, tbl[i].inst_e});
`ifdef MAC_TILE_OUT_REG_EN
            check($sformatf("tbl%0d_out_s", i), bus.out_s, tbl[i].out_s_reg);
`else
            check($sformatf("tbl%0d_out_s", i), bus.out_s, tbl[i].out_s);
`endif
            check_model($sformatf("tbl%0d_model", i));
        end

        // Asynchronous reset in the middle of an execute stream, then 2'b11 as the first token
        bus.inst_w = 2'b10;
        bus.in_w   = 4'h9;
        bus.in_n   = 16'd55;
        @(posedge clk);
        m_edge(2'b10, 4'h9, 16'd55);
        async_reset_pulse();
        step(2'b11, 4'h3, 16'h0000);
        check("load_exec_inst_e", {14'h0000, bus.inst_e}, 16'h0002);
        check("load_exec_out_e",  {12'h000, bus.out_e},  16'h0003);
        check_model("load_exec");
        step(2'b10, 4'h2, 16'h0000);
        check_model("after_reload_exec");
        step(2'b00, 4'h0, 16'h0000);
        check_model("after_reload_idle");

        // Wrap with weight 1
        @(negedge clk);
        async_reset_pulse();
        step(2'b01, 4'h1, 16'h0000);
        step(2'b10, 4'h1, 16'h7FFF);
`ifdef MAC_TILE_OUT_REG_EN
        step(2'b00, 4'h0, 16'h0000);
`endif
        check("wrap_out_s", bus.out_s, 16'h8000);
        check_model("wrap");

        // Randomized run against the model, with occasional resets
        for (int i = 0; i < 300; i++) begin
            logic [15:0] inn;
            if (i % 100 == 50) begin
                reset_n = 1'b0;
                m_reset();
                @(negedge clk);
                check_zero("rand_rst");
                reset_n = 1'b1;
            end
            inn = ($urandom_range(0, 3) == 0) ? 16'h7FFF - 16'($urandom_range(0, 8))
                                              : 16'($urandom);
            step(2'($urandom_range(0, 3)), 4'($urandom), inn);
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
